// File: rtl/cnn_pkg.sv
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared opcode/state encodings, instruction field positions
//                and status word layout for the CNN instruction dispatcher.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 28;
    localparam int unsigned REG_MSB = 27;
    localparam int unsigned REG_LSB = 24;
    localparam int unsigned IMM_MSB = 23;
    localparam int unsigned IMM_LSB = 0;

    localparam int unsigned STAT_BUSY     = 0;
    localparam int unsigned STAT_HALTED   = 1;
    localparam int unsigned STAT_ERROR    = 2;
    localparam int unsigned STAT_OVERFLOW = 3;
    localparam int unsigned STAT_CNT_LSB  = 4;
    localparam int unsigned STAT_CNT_MSB  = 8;
    localparam int unsigned STAT_OP_LSB   = 12;
    localparam int unsigned STAT_OP_MSB   = 15;
    localparam int unsigned STAT_DONE_LSB = 16;
    localparam int unsigned STAT_DONE_MSB = 31;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_CONV  = 4'h1,
        OP_POOL  = 4'h2,
        OP_LOAD  = 4'h3,
        OP_STORE = 4'h4,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HALTED = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    // Opcodes that are forwarded to the engine as a command.
    function automatic logic op_is_engine(input logic [3:0] op);
        return (op == OP_CONV) || (op == OP_POOL) ||
               (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fifo.sv
// ============================================================================
//  Module      : inst_fifo
//  Description : Power-of-two instruction queue with simultaneous push/pop.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/inst_dispatch.sv
// ============================================================================
//  Module      : inst_dispatch
//  Description : Queues instruction words, decodes them and hands commands to
//                the CNN engine with a ready/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_dispatch
    import cnn_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       inst_i,
    input  logic              inst_val_i,
    input  logic [31:0]       conf_i,
    input  logic [15:0][31:0] gp_i,
    output logic [31:0]       stat_o,
    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    output logic [3:0]        cmd_op_o,
    output logic [31:0]       cmd_opnd_o,
    output logic [23:0]       cmd_imm_o,
    input  logic              done_i
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] opnd_q, opnd_d;
    logic [3:0]  last_op_q, last_op_d;
    logic [15:0] done_cnt_q, done_cnt_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;
    logic [31:0] stat_q, stat_d;
    logic        err_set;

    logic             fifo_push;
    logic             fifo_pop;
    logic [31:0]      fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] fifo_cnt_next;
    logic [3:0]       dec_op;
    logic             unused_conf;

    assign unused_conf = ^conf_i[31:2];
    assign dec_op      = inst_q[OP_MSB:OP_LSB];

    assign fifo_pop  = (state_q == ST_IDLE) && conf_i[0] && !fifo_empty;
    assign fifo_push = inst_val_i && (!fifo_full || fifo_pop);

    inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (inst_i),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Occupancy after this edge, so the registered status is never a cycle stale.
    always_comb begin
        fifo_cnt_next = fifo_count;
        if (fifo_push && !fifo_pop) begin
            fifo_cnt_next = fifo_count + CNT_W'(1);
        end else if (!fifo_push && fifo_pop) begin
            fifo_cnt_next = fifo_count - CNT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        opnd_d     = opnd_q;
        last_op_d  = last_op_q;
        done_cnt_d = done_cnt_q;
        err_set    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fifo_pop) begin
                    inst_d  = fifo_head;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                opnd_d    = gp_i[inst_q[REG_MSB:REG_LSB]];
                last_op_d = dec_op;
                if (dec_op == OP_NOP) begin
                    state_d    = ST_IDLE;
                    done_cnt_d = done_cnt_q + 16'd1;
                end else if (dec_op == OP_HALT) begin
                    state_d = ST_HALTED;
                end else if (op_is_engine(dec_op)) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_ERR;
                    err_set = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done_i) begin
                    state_d    = ST_IDLE;
                    done_cnt_d = done_cnt_q + 16'd1;
                end
            end
            ST_HALTED: begin
                if (!conf_i[0]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (conf_i[1]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky flags: a set in the same cycle as a clear request takes priority.
    always_comb begin
        ovf_d = (inst_val_i && !fifo_push) || (ovf_q && !conf_i[1]);
        err_d = err_set || (err_q && !conf_i[1]);
    end

    always_comb begin
        stat_d                              = '0;
        stat_d[STAT_BUSY]                   = (state_d != ST_IDLE);
        stat_d[STAT_HALTED]                 = (state_d == ST_HALTED);
        stat_d[STAT_ERROR]                  = err_d;
        stat_d[STAT_OVERFLOW]               = ovf_d;
        stat_d[STAT_CNT_MSB:STAT_CNT_LSB]   = 5'(fifo_cnt_next);
        stat_d[STAT_OP_MSB:STAT_OP_LSB]     = last_op_d;
        stat_d[STAT_DONE_MSB:STAT_DONE_LSB] = done_cnt_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            inst_q     <= '0;
            opnd_q     <= '0;
            last_op_q  <= '0;
            done_cnt_q <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            stat_q     <= '0;
        end else begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            opnd_q     <= opnd_d;
            last_op_q  <= last_op_d;
            done_cnt_q <= done_cnt_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            stat_q     <= stat_d;
        end
    end

    assign stat_o      = stat_q;
    assign cmd_valid_o = (state_q == ST_ISSUE);
    assign cmd_op_o    = inst_q[OP_MSB:OP_LSB];
    assign cmd_imm_o   = inst_q[IMM_MSB:IMM_LSB];
    assign cmd_opnd_o  = opnd_q;

endmodule

`default_nettype wire

// File: doc/inst_dispatch.md
INST_DISPATCH -- requirements
Module: inst_dispatch

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, instruction queue depth (power of two, 2..16).
REQ-002 SHALL have port: clock  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: inst_i  in  32  instruction word from register file.
REQ-005 SHALL have port: inst_val_i  in  1  one-cycle pulse, inst_i valid.
REQ-006 SHALL have port: conf_i  in  32  config word; bit0 enable, bit1 clear sticky flags, others ignored.
REQ-007 SHALL have port: gp_i  in  16x32  general-purpose register array.
REQ-008 SHALL have port: stat_o  out  32  status word back to register file.
REQ-009 SHALL have port: cmd_valid_o  out  1  command offered to CNN engine.
REQ-010 SHALL have port: cmd_ready_i  in  1  engine accepts command.
REQ-011 SHALL have port: cmd_op_o  out  4  opcode; cmd_opnd_o  out  32  gp operand; cmd_imm_o  out  24  immediate.
REQ-012 SHALL have port: done_i  in  1  one-cycle pulse, engine finished current command.

Function
REQ-013 SHALL decode instruction as op=[31:28], reg index=[27:24], imm=[23:0].
REQ-014 SHALL treat opcodes: 0 NOP, 1 CONV, 2 POOL, 3 LOAD, 4 STORE, F HALT; all others illegal.
REQ-015 SHALL push inst_i into FIFO on clock edge where inst_val_i=1 and FIFO not full, or full with pop in same cycle.
REQ-016 SHALL drop inst_i when full without same-cycle pop, and set sticky overflow flag.
REQ-017 SHALL use FSM states IDLE, DECODE, ISSUE, WAIT, HALTED, ERR.
REQ-018 IDLE: if conf_i[0]=1 and FIFO non-empty -> DECODE, pop head into op register; else stay.
REQ-019 DECODE: capture gp_i[reg index] into operand register; NOP -> IDLE with completed count +1; HALT -> HALTED; illegal -> ERR with sticky error flag set; else -> ISSUE.
REQ-020 ISSUE: cmd_valid_o=1, cmd_op/opnd/imm held stable; on cmd_ready_i=1 -> WAIT.
REQ-021 WAIT: on done_i=1 -> IDLE, completed count +1; done_i in any other state ignored.
REQ-022 HALTED: -> IDLE when conf_i[0]=0.
REQ-023 ERR: -> IDLE when conf_i[1]=1; FIFO contents retained.
REQ-024 SHALL clear overflow and error sticky flags on any cycle with conf_i[1]=1; same-cycle set wins.
REQ-025 Latency: inst_val_i sampled at edge k into empty FIFO, FSM IDLE, enabled -> cmd_valid_o high after edge k+2.
REQ-026 stat_o: [0] busy (state != IDLE), [1] halted, [2] error, [3] overflow, [8:4] FIFO count, [11:9] 0, [15:12] last decoded opcode, [31:16] completed count, wrapping 0xFFFF->0.
REQ-027 stat_o SHALL be registered, reflecting state after the current edge.
REQ-028 conf_i[0] deassert during ISSUE/WAIT SHALL NOT abort the current command.

Reset
REQ-029 Reset SHALL empty FIFO, force IDLE, clear sticky flags, counter, last opcode; stat_o=0, cmd_valid_o=0, cmd_op_o/cmd_opnd_o/cmd_imm_o=0.
REQ-030 Reset asserted mid-ISSUE/WAIT SHALL abandon the command; a later done_i SHALL be ignored.

Structure
REQ-031 Opcode enum, state enum, stat_o bit positions, instruction field positions SHALL live in shared package cnn_pkg.
REQ-032 FIFO SHALL be a separate sub-module inst_fifo (push/pop/full/empty/count).

Verification
REQ-033 conf=1, push 0x1300_0010, gp[3]=0xDEADBEEF -> cmd_valid after 2 edges, op=1, opnd=0xDEADBEEF, imm=0x10; ready+done -> stat_o[31:16]=1, busy=0.
REQ-034 conf=0, push 5 words -> stat_o[8:4]=4, stat_o[3]=1; conf=2 -> stat_o[3]=0.
REQ-035 push 0x7000_0000 -> state ERR, stat_o[2]=1, no cmd_valid; conf=3 -> IDLE, next queued instruction issues.
REQ-036 push HALT then NOP -> stat_o[1]=1, NOP stays queued; conf=0 then 1 -> NOP retires, count +1.
REQ-037 cmd_ready_i held low 10 cycles -> outputs stable; reset pulse in WAIT -> stat_o=0, subsequent done_i ignored.
REQ-038 push on full FIFO same cycle as pop -> accepted, count stays 4, no overflow.
